// File: rtl/sram_pkg.sv
// Shared encodings for the SRAM pattern engine: FSM states, pattern modes and
// checkerboard words (sliced down to DATA_W by the users).
package sram_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_SETUP,
      S_WR_STROBE,
      S_RD_ADDR,
      S_RD_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [1:0] MODE_DESC  = 2'd0;
   localparam logic [1:0] MODE_ASC   = 2'd1;
   localparam logic [1:0] MODE_CHECK = 2'd2;
   localparam logic [1:0] MODE_INV   = 2'd3;

   localparam logic [63:0] CHECK_EVEN = {32{2'b01}};
   localparam logic [63:0] CHECK_ODD  = {32{2'b10}};

endpackage

// File: rtl/sram_pattern_gen.sv
// Combinational data pattern for word index i; shared by the write data path
// and the read-back comparator. All results wrap modulo 2^DATA_W.
module sram_pattern_gen
   import sram_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 128
) (
   input  logic [ADDR_W-1:0] i_idx,
   input  logic [1:0]        i_mode,
   output logic [DATA_W-1:0] o_pattern
);

   always_comb begin
      o_pattern = DATA_W'(i_idx);
      case (i_mode)
         MODE_DESC:  o_pattern = DATA_W'(32'(DEPTH) - 32'd1 - 32'(i_idx));
         MODE_ASC:   o_pattern = DATA_W'(i_idx);
         MODE_CHECK: o_pattern = i_idx[0] ? DATA_W'(CHECK_ODD) : DATA_W'(CHECK_EVEN);
         MODE_INV:   o_pattern = ~DATA_W'(i_idx);
         default:    o_pattern = DATA_W'(i_idx);
      endcase
   end

endmodule

// File: rtl/sram_pattern_engine.sv
// Writes a selectable pattern into the first DEPTH SRAM words and reads them back.
// Optional read-back comparator and mismatch counter: define SRAM_VERIFY_EN.
module sram_pattern_engine
   import sram_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 128,
   parameter int ERR_W  = ADDR_W + 1
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start_write,
   input  logic              start_read,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] sram_adrx,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              drive_en,
   output logic              sram_we_n,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ERR_W-1:0]  err_count
);

   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_idx, w_idx_next;
   logic [1:0]        r_mode, w_mode_next;
   logic              w_last;
   logic [DATA_W-1:0] w_pattern;

   logic [ADDR_W-1:0] r_adrx;
   logic [DATA_W-1:0] r_wdata, r_rd_data;
   logic              r_drive_en, r_we_n, r_busy, r_done, r_rd_valid;

   assign w_last = (r_idx == ADDR_W'(DEPTH - 1));

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_mode_next  = r_mode;
      case (r_state)
         S_IDLE: begin
            if (start_read) begin
               w_state_next = S_RD_ADDR;
               w_idx_next   = '0;
               w_mode_next  = mode;
            end else if (start_write) begin
               w_state_next = S_WR_SETUP;
               w_idx_next   = '0;
               w_mode_next  = mode;
            end
         end
         S_WR_SETUP:  w_state_next = S_WR_STROBE;
         S_WR_STROBE: begin
            if (w_last) w_state_next = S_DONE;
            else begin
               w_state_next = S_WR_SETUP;
               w_idx_next   = r_idx + 1'b1;
            end
         end
         S_RD_ADDR:   w_state_next = S_RD_SAMPLE;
         S_RD_SAMPLE: begin
            if (w_last) w_state_next = S_DONE;
            else begin
               w_state_next = S_RD_ADDR;
               w_idx_next   = r_idx + 1'b1;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Fed with the next index/mode so the registered bus outputs line up with the state.
   sram_pattern_gen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_gen (
      .i_idx     (w_idx_next),
      .i_mode    (w_mode_next),
      .o_pattern (w_pattern)
   );

   // Bus controls come straight from flops so the SRAM never sees a decode glitch.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_mode     <= MODE_DESC;
         r_adrx     <= '0;
         r_wdata    <= '0;
         r_drive_en <= 1'b0;
         r_we_n     <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_idx      <= w_idx_next;
         r_mode     <= w_mode_next;
         r_adrx     <= (w_state_next == S_IDLE || w_state_next == S_DONE) ? '0 : w_idx_next;
         if (w_state_next == S_WR_SETUP) r_wdata <= w_pattern;
         r_drive_en <= (w_state_next == S_WR_SETUP) || (w_state_next == S_WR_STROBE);
         r_we_n     <= (w_state_next != S_WR_STROBE);
         r_busy     <= (w_state_next != S_IDLE);
         r_done     <= (w_state_next == S_DONE);
         r_rd_valid <= (w_state_next == S_RD_SAMPLE);
         if (w_state_next == S_RD_SAMPLE) r_rd_data <= sram_rdata;
      end
   end

`ifdef SRAM_VERIFY_EN
   logic [ERR_W-1:0] r_err;
   logic             w_rd_start;

   assign w_rd_start = (r_state == S_IDLE) && (w_state_next == S_RD_ADDR);

   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         r_err <= '0;
      else if (w_rd_start)
         r_err <= '0;
      else if (w_state_next == S_RD_SAMPLE && sram_rdata != w_pattern && r_err != '1)
         r_err <= r_err + 1'b1;
   end

   assign err_count = r_err;
`else
   assign err_count = '0;
`endif

   assign sram_adrx  = r_adrx;
   assign sram_wdata = r_wdata;
   assign drive_en   = r_drive_en;
   assign sram_we_n  = r_we_n;
   assign busy       = r_busy;
   assign done       = r_done;
   assign rd_data    = r_rd_data;
   assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_sram_pattern_engine.sv
// Self-checking bench for sram_pattern_engine: behavioural SRAM plus a pattern
// reference model; a second instance covers DEPTH=1, DATA_W=4.
module tb_sram_pattern_engine;

   localparam int DEPTH = 128;

   logic       clock = 1'b0;
   logic       rst   = 1'b1;
   logic       sw = 1'b0, sr = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] adrx, wdata, rdata, rd_data;
   logic       de, we_n, busy, done, rd_valid;
   logic [8:0] err;

   logic       s1w = 1'b0, s1r = 1'b0;
   logic [1:0] m1 = 2'd0;
   logic [7:0] adrx1;
   logic [3:0] wd1, rdat1, rd1;
   logic       de1, we1_n, busy1, done1, rv1;
   logic [8:0] err1;

   logic [7:0] mem [256];
   logic [3:0] mem1;

   int errors = 0;
   int checks = 0;

   int cyc, strobes, valids, stab_err, busy_lo, de_hi, first_a, err_at1;
   logic [7:0] rdq [$];

   always #5 clock = ~clock;

   assign rdata = de  ? 8'h00 : mem[adrx];
   assign rdat1 = de1 ? 4'h0  : mem1;

   sram_pattern_engine dut (
      .clock(clock), .rst(rst), .start_write(sw), .start_read(sr), .mode(mode),
      .sram_adrx(adrx), .sram_wdata(wdata), .drive_en(de), .sram_we_n(we_n),
      .sram_rdata(rdata), .busy(busy), .done(done), .rd_data(rd_data),
      .rd_valid(rd_valid), .err_count(err)
   );

   sram_pattern_engine #(.ADDR_W(8), .DATA_W(4), .DEPTH(1), .ERR_W(9)) dut1 (
      .clock(clock), .rst(rst), .start_write(s1w), .start_read(s1r), .mode(m1),
      .sram_adrx(adrx1), .sram_wdata(wd1), .drive_en(de1), .sram_we_n(we1_n),
      .sram_rdata(rdat1), .busy(busy1), .done(done1), .rd_data(rd1),
      .rd_valid(rv1), .err_count(err1)
   );

   function automatic int pat(input int m, input int i, input int depth, input int w);
      int v;
      case (m)
         0:       v = depth - 1 - i;
         1:       v = i;
         2:       v = (i % 2 == 1) ? 'hAA : 'h55;
         default: v = ~i;
      endcase
      return v & ((1 << w) - 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One pass on the main instance; poke>0 pulses start_write at that cycle.
   task automatic run_pass(input bit rd, input bit wr, input logic [1:0] m, input int poke);
      logic [7:0] pa, pd;
      @(negedge clock);
      sr = rd; sw = wr; mode = m;
      @(posedge clock);
      #1;
      sr = 1'b0; sw = 1'b0; mode = 2'($urandom);
      cyc = 0; strobes = 0; valids = 0; stab_err = 0; busy_lo = 0; de_hi = 0;
      first_a = -1; err_at1 = -1; rdq.delete();
      pa = adrx; pd = wdata;
      while (cyc < 2000) begin
         @(negedge clock);
         cyc++;
         if (cyc == 1) err_at1 = int'(err);
         if (!busy) busy_lo++;
         if (de) de_hi++;
         if (!we_n) begin
            strobes++;
            if (adrx !== pa || wdata !== pd) stab_err++;
            if (first_a < 0) first_a = int'(adrx);
            mem[adrx] = wdata;
         end
         if (rd_valid) rdq.push_back(rd_data);
         sw = (cyc == poke);
         pa = adrx; pd = wdata;
         if (done) break;
      end
      sw = 1'b0;
   endtask

   task automatic run1(input bit rd, input logic [1:0] m);
      @(negedge clock);
      s1r = rd; s1w = !rd; m1 = m;
      @(posedge clock);
      #1;
      s1r = 1'b0; s1w = 1'b0;
      cyc = 0; strobes = 0; valids = 0; rdq.delete();
      while (cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (!we1_n) begin strobes++; mem1 = wd1; end
         if (rv1) begin valids++; rdq.push_back({4'h0, rd1}); end
         if (done1) break;
      end
   endtask

   initial begin
      int bad, a1, a2, experr;
      logic [1:0] m;

      for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
      mem1 = 4'h0;

      // reset state
      #12;
      check("rst_we_n", 32'(we_n), 32'd1);
      check("rst_adrx", 32'(adrx), 32'd0);
      check("rst_wdata", 32'(wdata), 32'd0);
      check("rst_ctrl", {28'd0, de, busy, done, rd_valid}, 32'd0);
      check("rst_rd_err", {15'd0, err, rd_data}, 32'd0);
      @(negedge clock);
      rst = 1'b0;

      // write pass, descending
      run_pass(1'b0, 1'b1, 2'd0, 0);
      check("wr_done_cycle", 32'(cyc), 32'd257);
      check("wr_strobes", 32'(strobes), 32'd128);
      check("wr_stable", 32'(stab_err), 32'd0);
      check("wr_busy_gap", 32'(busy_lo), 32'd0);
      check("wr_word5", 32'(mem[5]), 32'h7A);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) != pat(0, i, DEPTH, 8)) bad++;
      check("wr_desc_image", 32'(bad), 32'd0);
      @(negedge clock);
      check("wr_busy_after", 32'(busy), 32'd0);

      // read pass of descending image
      run_pass(1'b1, 1'b0, 2'd0, 0);
      check("rd_done_cycle", 32'(cyc), 32'd257);
      check("rd_valids", 32'(rdq.size()), 32'd128);
      check("rd_first", 32'(rdq[0]), 32'h7F);
      check("rd_last", 32'(rdq[DEPTH-1]), 32'h00);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (i >= rdq.size() || int'(rdq[i]) != pat(0, i, DEPTH, 8)) bad++;
      check("rd_sequence", 32'(bad), 32'd0);
      check("rd_err_clean", 32'(err), 32'd0);
      check("rd_no_drive", 32'(de_hi + strobes), 32'd0);

      // random modes, corruption, start priority, start while busy
      for (int it = 0; it < 3; it++) begin
         m = 2'($urandom_range(0, 3));
         run_pass(1'b0, 1'b1, m, 0);
         bad = 0;
         for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) != pat(int'(m), i, DEPTH, 8)) bad++;
         check("rnd_wr_image", 32'(bad), 32'd0);
         check("rnd_wr_first_addr", 32'(first_a), 32'd0);
         a1 = $urandom_range(0, DEPTH - 1);
         a2 = (a1 + $urandom_range(1, DEPTH - 1)) % DEPTH;
         if (it == 0) begin a1 = 3; a2 = 100; end
         mem[a1] = mem[a1] ^ 8'(($urandom_range(0, 254)) + 1);
         mem[a2] = mem[a2] ^ 8'(($urandom_range(0, 254)) + 1);
         experr = 0;
`ifdef SRAM_VERIFY_EN
         for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) != pat(int'(m), i, DEPTH, 8)) experr++;
`endif
         run_pass(1'b1, 1'b1, m, 20);
         check("prio_no_strobe", 32'(strobes + de_hi), 32'd0);
         check("prio_rd_cycles", 32'(cyc), 32'd257);
         bad = 0;
         for (int i = 0; i < DEPTH; i++) if (i >= rdq.size() || rdq[i] !== mem[i]) bad++;
         check("rnd_rd_data", 32'(bad), 32'd0);
         check("rnd_err", 32'(err), 32'(experr));
         @(negedge clock);
         check("busy_poke_ignored", 32'(busy), 32'd0);
         run_pass(1'b1, 1'b0, m, 0);
         check("rd2_err_cleared", 32'(err_at1), 32'd0);
         check("rd2_err", 32'(err), 32'(experr));
      end

      // asynchronous reset in the middle of word 40's strobe
      @(negedge clock);
      sw = 1'b1; mode = 2'd0;
      @(posedge clock);
      #1 sw = 1'b0;
      repeat (82) @(negedge clock);
      check("mid_adrx40", {23'd0, we_n, adrx}, 32'd40);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_we_n", 32'(we_n), 32'd1);
      check("mid_rst_outs", {21'd0, de, busy, done, adrx}, 32'd0);
      @(negedge clock);
      rst = 1'b0;
      run_pass(1'b0, 1'b1, 2'd1, 0);
      check("post_rst_first_addr", 32'(first_a), 32'd0);
      check("post_rst_cycles", 32'(cyc), 32'd257);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (int'(mem[i]) != pat(1, i, DEPTH, 8)) bad++;
      check("post_rst_image", 32'(bad), 32'd0);

      // DEPTH=1, DATA_W=4 instance
      run1(1'b0, 2'd2);
      check("d1_wr_data", 32'(mem1), 32'(pat(2, 0, 1, 4)));
      check("d1_wr_done", 32'(cyc), 32'd3);
      check("d1_wr_strobes", 32'(strobes), 32'd1);
      run1(1'b0, 2'd3);
      run1(1'b1, 2'd3);
      check("d1_rd_valids", 32'(valids), 32'd1);
      check("d1_rd_data", 32'(rdq.size() > 0 ? rdq[0] : 8'hEE), 32'h0F);
      check("d1_rd_done", 32'(cyc), 32'd3);
      check("d1_rd_err", 32'(err1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
